dmem_ls_unit: RTL

//  Load/store initiator for the 12-bit microcontroller data memory (DMem).

---
 rtl/dmem_ls_unit.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/dmem_ls_unit.sv
// Load/store initiator for the 12-bit microcontroller data memory.
// Scrubs DMem after reset, then serves one read or write per request/response handshake.
module dmem_ls_unit #(
  parameter int                 DATA_W   = 8,
  parameter int                 ADDR_W   = 4,
  parameter int                 RD_LAT   = 0,
  parameter logic [DATA_W-1:0]  INIT_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              init_done,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_WR,
    S_RD,
    S_RESP
  } state_t;

  localparam int              DEPTH      = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] SCRUB_END  = DEPTH[ADDR_W:0];
  localparam logic [1:0]      LAT_LAST   = 2'(RD_LAT);

  state_t              state, state_d;
  logic [ADDR_W:0]     scrub_cnt, scrub_cnt_d;
  logic [1:0]          lat_cnt, lat_cnt_d;
  logic                req_ready_d;
  logic                rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_d;
  logic                init_done_d;
  logic                mem_en_d;
  logic                mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_d;

  // Every output is a flop; reset clears them all and restarts the scrub.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_INIT;
      scrub_cnt <= '0;
      lat_cnt   <= '0;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      init_done <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      state     <= state_d;
      scrub_cnt <= scrub_cnt_d;
      lat_cnt   <= lat_cnt_d;
      req_ready <= req_ready_d;
      rsp_valid <= rsp_valid_d;
      rsp_rdata <= rsp_rdata_d;
      init_done <= init_done_d;
      mem_en    <= mem_en_d;
      mem_we    <= mem_we_d;
      mem_addr  <= mem_addr_d;
      mem_wdata <= mem_wdata_d;
    end
  end

  always_comb begin
    state_d     = state;
    scrub_cnt_d = scrub_cnt;
    lat_cnt_d   = lat_cnt;
    req_ready_d = req_ready;
    rsp_valid_d = rsp_valid;
    rsp_rdata_d = rsp_rdata;
    init_done_d = init_done;
    mem_en_d    = mem_en;
    mem_we_d    = mem_we;
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;

    case (state)
      S_INIT: begin
        req_ready_d = 1'b0;
        if (scrub_cnt == SCRUB_END) begin
          init_done_d = 1'b1;
          mem_en_d    = 1'b0;
          mem_we_d    = 1'b0;
          req_ready_d = 1'b1;
          state_d     = S_IDLE;
        end else begin
          mem_en_d    = 1'b1;
          mem_we_d    = 1'b1;
          mem_addr_d  = scrub_cnt[ADDR_W-1:0];
          mem_wdata_d = INIT_VAL;
          scrub_cnt_d = scrub_cnt + (ADDR_W + 1)'(1);
        end
      end

      // The memory port registers double as the request latch.
      S_IDLE: begin
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        req_ready_d = 1'b1;
        if (req_valid && req_ready) begin
          req_ready_d = 1'b0;
          mem_en_d    = 1'b1;
          mem_we_d    = req_we;
          mem_addr_d  = req_addr;
          lat_cnt_d   = '0;
          if (req_we) begin
            mem_wdata_d = req_wdata;
            state_d     = S_WR;
          end else begin
            state_d     = S_RD;
          end
        end
      end

      S_WR: begin
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        rsp_valid_d = 1'b1;
        rsp_rdata_d = mem_wdata;
        state_d     = S_RESP;
      end

      S_RD: begin
        if (lat_cnt == LAT_LAST) begin
          mem_en_d    = 1'b0;
          mem_we_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = mem_rdata;
          state_d     = S_RESP;
        end else begin
          lat_cnt_d   = lat_cnt + 2'd1;
        end
      end

      S_RESP: begin
        mem_en_d = 1'b0;
        mem_we_d = 1'b0;
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          req_ready_d = 1'b1;
          state_d     = S_IDLE;
        end
      end

      default: begin
        state_d = S_INIT;
      end
    endcase
  end

endmodule
